// File: rtl/d5m_pkg.sv
// Shared types and helpers for the D5M frame reader.
// Bus widths, FSM encodings and the burst-length helper.
package d5m_pkg;

  localparam int PIX_W      = 12;
  localparam int BURST_W    = 5;
  localparam int AVM_ADDR_W = 32;
  localparam int AVM_DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_EMIT   = 3'd2;
  localparam state_t ST_HBLANK = 3'd3;
  localparam state_t ST_VBLANK = 3'd4;

  function automatic logic [BURST_W-1:0] min_burst(
    input logic [15:0] remaining,
    input logic [15:0] max_burst
  );
    logic [15:0] m;
    m = (remaining < max_burst) ? remaining : max_burst;
    return m[BURST_W-1:0];
  endfunction

endpackage

// File: rtl/d5m_line_fifo.sv
// Show-ahead line buffer: rd_data always presents the oldest entry.
// Holds one full line so the emitted line never stalls.
module d5m_line_fifo
  import d5m_pkg::*;
#(
  parameter int DEPTH = 2048,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             pop,
  output logic [PIX_W-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(pop && empty)) else $error("line fifo pop when empty");
      assert (!(push && full)) else $error("line fifo push when full");
    end
  end
`endif

endmodule

// File: rtl/d5m_frame_reader.sv
// Avalon-MM burst reader replaying a stored frame as a D5M pixel stream.
// A whole line is fetched into the FIFO before line_valid rises.
module d5m_frame_reader
  import d5m_pkg::*;
#(
  parameter int MAX_WIDTH = 2048,
  parameter int MAX_BURST = 16,
  parameter int H_BLANK   = 16,
  parameter int V_BLANK   = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [11:0]           frame_width,
  input  logic [11:0]           frame_height,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [AVM_ADDR_W-1:0] master_address,
  output logic                  master_read,
  output logic [BURST_W-1:0]    master_burstcount,
  output logic [3:0]            master_byteenable,
  input  logic [AVM_DATA_W-1:0] master_readdata,
  input  logic                  master_readdatavalid,
  input  logic                  master_waitrequest,
  output logic                  d5m_frame_valid,
  output logic                  d5m_line_valid,
  output logic [PIX_W-1:0]      d5m_data
);

  localparam int WC_W    = $clog2(MAX_WIDTH) + 1;
  localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BK_W    = $clog2(BLK_MAX + 1);
  localparam int FC_W    = $clog2(MAX_WIDTH) + 1;
  localparam logic [12:0] MAX_W13 = 13'(MAX_WIDTH);
  localparam logic [15:0] MAXB16  = 16'(MAX_BURST);

  state_t                state;
  logic [AVM_ADDR_W-1:0] addr;
  logic [BURST_W-1:0]    bcnt;
  logic                  read_r;
  logic [WC_W-1:0]       width_r;
  logic [WC_W-1:0]       req_left;
  logic [WC_W-1:0]       rcv_cnt;
  logic [WC_W-1:0]       pix_left;
  logic [11:0]           line_left;
  logic [BK_W-1:0]       blk_cnt;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  start_ok;
  logic [WC_W-1:0]       req_next;
  logic [AVM_ADDR_W-1:0] addr_next;
  logic [PIX_W-1:0]      fifo_rd;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FC_W-1:0]       fifo_count;
  logic                  unused_ok;

  assign accept    = read_r & ~master_waitrequest;
  assign push      = master_readdatavalid && (state == ST_FETCH);
  assign pop       = (state == ST_EMIT);
  assign start_ok  = (frame_width != '0) && (frame_height != '0)
                  && ({1'b0, frame_width} <= MAX_W13);
  assign req_next  = req_left - WC_W'(bcnt);
  assign addr_next = addr
                   + {{(AVM_ADDR_W-BURST_W-2){1'b0}}, bcnt, 2'b00};

  d5m_line_fifo #(.DEPTH(MAX_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (master_readdata[PIX_W-1:0]),
    .pop     (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      addr            <= '0;
      bcnt            <= '0;
      read_r          <= 1'b0;
      width_r         <= '0;
      req_left        <= '0;
      rcv_cnt         <= '0;
      pix_left        <= '0;
      line_left       <= '0;
      blk_cnt         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      d5m_frame_valid <= 1'b0;
      d5m_line_valid  <= 1'b0;
      d5m_data        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              addr            <= base_addr;
              width_r         <= WC_W'(frame_width);
              req_left        <= WC_W'(frame_width);
              rcv_cnt         <= '0;
              line_left       <= frame_height;
              bcnt            <= min_burst(16'(frame_width), MAXB16);
              read_r          <= 1'b1;
              busy            <= 1'b1;
              d5m_frame_valid <= 1'b1;
              state           <= ST_FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          // Keep read high back-to-back while words remain to request.
          if (accept) begin
            addr     <= addr_next;
            req_left <= req_next;
            if (req_next != '0) bcnt <= min_burst(16'(req_next), MAXB16);
            else read_r <= 1'b0;
          end
          if (push) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == width_r - WC_W'(1)) begin
              pix_left <= width_r;
              state    <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          d5m_line_valid <= 1'b1;
          d5m_data       <= fifo_rd;
          pix_left       <= pix_left - 1'b1;
          if (pix_left == WC_W'(1)) begin
            blk_cnt <= BK_W'(H_BLANK);
            state   <= ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          d5m_line_valid <= 1'b0;
          d5m_data       <= '0;
          blk_cnt        <= blk_cnt - 1'b1;
          if (blk_cnt == BK_W'(1)) begin
            if (line_left == 12'd1) begin
              d5m_frame_valid <= 1'b0;
              blk_cnt         <= BK_W'(V_BLANK);
              state           <= ST_VBLANK;
            end else begin
              line_left <= line_left - 12'd1;
              req_left  <= width_r;
              rcv_cnt   <= '0;
              bcnt      <= min_burst(16'(width_r), MAXB16);
              read_r    <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_VBLANK: begin
          blk_cnt <= blk_cnt - 1'b1;
          if (blk_cnt == BK_W'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign master_address    = addr;
  assign master_read       = read_r;
  assign master_burstcount = bcnt;
  assign master_byteenable = 4'hF;

  assign unused_ok = ^{master_readdata[AVM_DATA_W-1:PIX_W], fifo_full};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && state == ST_EMIT) begin
      assert (!fifo_empty) else $error("line fifo underrun during EMIT");
      assert (pix_left != WC_W'(1) || fifo_count == FC_W'(1))
        else $error("line fifo not drained at end of line");
    end
  end
`endif

endmodule

// File: tb/tb_d5m_frame_reader.sv
// Randomized bench with a behavioural memory/stream model for d5m_frame_reader.
module tb_d5m_frame_reader;

  localparam int MAXW  = 128;
  localparam int MAXB  = 16;
  localparam int HB    = 4;
  localparam int VB    = 8;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [11:0] frame_width = '0;
  logic [11:0] frame_height = '0;
  logic        busy, done, err;
  logic [31:0] master_address;
  logic        master_read;
  logic [4:0]  master_burstcount;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest = 1'b0;
  logic        d5m_frame_valid, d5m_line_valid;
  logic [11:0] d5m_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_baddr[$];
  int          exp_blen[$];
  logic [11:0] exp_pix[$];
  logic [31:0] beat_q[$];
  logic [31:0] log_addr[$];
  int          log_bc[$];
  logic [11:0] log_pix[$];

  int gap_max = 0;
  int wait_pct = 0;
  int cur_w = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit lv_prev = 0;
  bit seen = 0;
  int run = 0;
  int lo_run = 0;
  int fv_lo = 0;

  always #5 clk = ~clk;

  d5m_frame_reader #(
    .MAX_WIDTH(MAXW), .MAX_BURST(MAXB), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .frame_width(frame_width),
    .frame_height(frame_height), .busy(busy), .done(done), .err(err),
    .master_address(master_address), .master_read(master_read),
    .master_burstcount(master_burstcount),
    .master_byteenable(master_byteenable),
    .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .d5m_frame_valid(d5m_frame_valid), .d5m_line_valid(d5m_line_valid),
    .d5m_data(d5m_data)
  );

  function automatic logic [11:0] pix(input logic [31:0] a);
    logic [31:0] t;
    t = (a >> 2) - 32'h400;
    return t[11:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Memory slave: random stalls, random beat gaps, data from pix().
  initial begin : slave
    int gap;
    bit held, w;
    logic [31:0] h_addr;
    logic [4:0]  h_bc;
    gap = 0;
    held = 0;
    h_addr = '0;
    h_bc = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        beat_q.delete();
        master_readdatavalid = 1'b0;
        master_waitrequest = 1'b0;
        held = 0;
        gap = 0;
      end else begin
        if (held) begin
          chk("addr_stable", master_address, h_addr);
          chk("bc_stable", {27'd0, master_burstcount}, {27'd0, h_bc});
          chk("read_held", {31'd0, master_read}, 1);
        end
        if (gap > 0) begin
          gap--;
          master_readdatavalid = 1'b0;
        end else if (beat_q.size() > 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = beat_q.pop_front();
          gap = $urandom_range(gap_max, 0);
        end else begin
          master_readdatavalid = 1'b0;
        end
        if (!master_readdatavalid) master_readdata = $urandom();
        w = ($urandom_range(99, 0) < wait_pct);
        master_waitrequest = w;
        held = master_read && w;
        h_addr = master_address;
        h_bc = master_burstcount;
        if (master_read && !w) begin
          log_addr.push_back(master_address);
          log_bc.push_back(int'(master_burstcount));
          chk("byteenable", {28'd0, master_byteenable}, 32'hF);
          if (exp_baddr.size() == 0) fail("burst_extra");
          else begin
            chk("burst_addr", master_address, exp_baddr.pop_front());
            chk("burst_len", {27'd0, master_burstcount}, exp_blen.pop_front());
          end
          for (int i = 0; i < int'(master_burstcount); i++)
            beat_q.push_back({20'($urandom()), pix(master_address + 32'(4 * i))});
        end
      end
    end
  end

  // Stream compare process against the expected pixel queue.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (d5m_frame_valid) chk("busy_in_frame", {31'd0, busy}, 1);
        if (d5m_line_valid) begin
          chk("line_in_frame", {31'd0, d5m_frame_valid}, 1);
          log_pix.push_back(d5m_data);
          if (exp_pix.size() == 0) fail("pix_extra");
          else chk("pixel", {20'd0, d5m_data}, {20'd0, exp_pix.pop_front()});
          if (!lv_prev && seen) chk("hblank_gap", {31'd0, lo_run >= HB}, 1);
          run++;
          lo_run = 0;
        end else begin
          chk("data_idle", {20'd0, d5m_data}, 0);
          if (lv_prev) begin
            chk("line_len", run, cur_w);
            seen = 1;
          end
          run = 0;
          lo_run++;
        end
        if (done) begin
          chk("done_fv_low", {31'd0, d5m_frame_valid}, 0);
          chk("vblank_len", {31'd0, fv_lo >= VB}, 1);
          chk("done_busy", {31'd0, busy}, 0);
          done_cnt++;
        end
        if (err) err_cnt++;
        if (d5m_frame_valid) fv_lo = 0;
        else begin
          fv_lo++;
          seen = 0;
        end
        lv_prev = d5m_line_valid;
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_read", {31'd0, master_read}, 0);
    chk("rst_addr", master_address, 0);
    chk("rst_bc", {27'd0, master_burstcount}, 0);
    chk("rst_be", {28'd0, master_byteenable}, 32'hF);
    chk("rst_fv", {31'd0, d5m_frame_valid}, 0);
    chk("rst_lv", {31'd0, d5m_line_valid}, 0);
    chk("rst_data", {20'd0, d5m_data}, 0);
  endtask

  task automatic issue_start(input logic [31:0] base, input int w, input int h);
    logic [31:0] a;
    int rem, len;
    cur_w = w;
    a = base;
    for (int l = 0; l < h; l++) begin
      rem = w;
      while (rem > 0) begin
        len = (rem > MAXB) ? MAXB : rem;
        exp_baddr.push_back(a);
        exp_blen.push_back(len);
        for (int i = 0; i < len; i++) exp_pix.push_back(pix(a + 32'(4 * i)));
        a = a + 32'(4 * len);
        rem -= len;
      end
    end
    @(negedge clk);
    base_addr = base;
    frame_width = 12'(w);
    frame_height = 12'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", {31'd0, busy}, 1);
    chk("fv_on", {31'd0, d5m_frame_valid}, 1);
  endtask

  task automatic run_frame(input logic [31:0] base, input int w, input int h,
                           input int gmax, input int wpct, input bit poke);
    int d0, e0, cyc;
    bit poked;
    gap_max = gmax;
    wait_pct = wpct;
    d0 = done_cnt;
    e0 = err_cnt;
    issue_start(base, w, h);
    cyc = 0;
    poked = 0;
    while (done_cnt == d0 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (start) start = 1'b0;
      if (poke && !poked && d5m_line_valid) begin
        start = 1'b1;
        poked = 1;
      end
    end
    chk("frame_timeout", {31'd0, cyc < LIMIT}, 1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("no_err", err_cnt - e0, 0);
    chk("pix_drained", exp_pix.size(), 0);
    chk("bursts_drained", exp_baddr.size(), 0);
    chk("busy_off", {31'd0, busy}, 0);
    chk("read_off", {31'd0, master_read}, 0);
  endtask

  task automatic bad_start(input int w, input int h);
    int e0;
    bit rd, bz;
    e0 = err_cnt;
    rd = 0;
    bz = 0;
    @(negedge clk);
    frame_width = 12'(w);
    frame_height = 12'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", {31'd0, err}, 1);
    repeat (8) begin
      @(negedge clk);
      rd |= master_read;
      bz |= busy;
    end
    chk("err_once", err_cnt - e0, 1);
    chk("err_no_read", {31'd0, rd}, 0);
    chk("err_no_busy", {31'd0, bz}, 0);
  endtask

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    log_addr.delete(); log_bc.delete(); log_pix.delete();
    run_frame(32'h1000, 4, 2, 0, 0, 0);
    chk("t1_nbursts", log_addr.size(), 2);
    chk("t1_addr0", log_addr[0], 32'h1000);
    chk("t1_addr1", log_addr[1], 32'h1010);
    chk("t1_bc0", log_bc[0], 4);
    chk("t1_bc1", log_bc[1], 4);
    chk("t1_npix", log_pix.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_pix_lit", {20'd0, log_pix[i]}, i);

    log_addr.delete(); log_bc.delete(); log_pix.delete();
    run_frame(32'h2000, 40, 1, 1, 50, 0);
    chk("t2_nbursts", log_addr.size(), 3);
    chk("t2_addr0", log_addr[0], 32'h2000);
    chk("t2_addr1", log_addr[1], 32'h2040);
    chk("t2_addr2", log_addr[2], 32'h2080);
    chk("t2_bc0", log_bc[0], 16);
    chk("t2_bc1", log_bc[1], 16);
    chk("t2_bc2", log_bc[2], 8);

    run_frame(32'h8000, 100, 2, 20, 30, 0);

    bad_start(0, 1);
    bad_start(MAXW + 1, 1);
    bad_start(5, 0);

    run_frame(32'h3000, 20, 3, 2, 20, 1);
    run_frame(32'h6000, MAXW, 1, 0, 25, 0);
    run_frame(32'hFFFF_FFC0, 64, 2, 1, 10, 0);
    for (int k = 0; k < 4; k++)
      run_frame($urandom() & 32'hFFFF_FFFC, $urandom_range(MAXW, 1),
                $urandom_range(3, 1), $urandom_range(3, 0),
                $urandom_range(40, 0), 0);

    // Reset in the middle of a line fetch, then a single-pixel frame.
    gap_max = 2;
    wait_pct = 20;
    issue_start(32'h4000, 40, 3);
    cyc = 0;
    while (!master_read && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("midfetch_reached", {31'd0, master_read}, 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs();
    exp_baddr.delete(); exp_blen.delete(); exp_pix.delete();
    lv_prev = 0; seen = 0; run = 0; lo_run = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    log_addr.delete(); log_bc.delete(); log_pix.delete();
    run_frame(32'h1024, 1, 1, 0, 0, 0);
    chk("t6_nbursts", log_addr.size(), 1);
    chk("t6_addr", log_addr[0], 32'h1024);
    chk("t6_bc", log_bc[0], 1);
    chk("t6_npix", log_pix.size(), 1);
    chk("t6_pix_lit", {20'd0, log_pix[0]}, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
